// File: rtl/bram_port_arbiter.sv
// -----------------------------------------------------------------------------
// bram_port_arbiter
//
// Two-requester round-robin arbiter for the shared port of a dual-port BRAM.
// One access is granted per cycle. The winning access is registered onto the
// memory port, and read data is steered back to the requester that issued it.
//
// Optional feature: define ARB_BURST_LOCK_EN to build the IDLE/LOCK0/LOCK1
// burst-lock FSM. A requester can then keep the port for up to MAX_BURST
// consecutive grants. Without the macro, r0_lock/r1_lock are ignored.
//
// Ports
//   clk, reset            clock, asynchronous active-high reset
//   rN_req/we/addr/wdata  access request and its qualifiers, held until granted
//   rN_lock               burst-lock request (ARB_BURST_LOCK_EN only)
//   rN_gnt                combinational grant (access accepted this cycle)
//   rN_rvalid, rN_rdata   one-cycle read return strobe and data
//   mem_addr/data/we      registered BRAM port drive
//   mem_q                 BRAM read data
// -----------------------------------------------------------------------------
module bram_port_arbiter #(
   parameter int WIDTH      = 16,
   parameter int ADDR_WIDTH = 16,
   parameter int RD_LATENCY = 1,
   parameter int MAX_BURST  = 8
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  r0_req,
   input  logic                  r0_we,
   input  logic [ADDR_WIDTH-1:0] r0_addr,
   input  logic [WIDTH-1:0]      r0_wdata,
   input  logic                  r0_lock,
   input  logic                  r1_req,
   input  logic                  r1_we,
   input  logic [ADDR_WIDTH-1:0] r1_addr,
   input  logic [WIDTH-1:0]      r1_wdata,
   input  logic                  r1_lock,
   output logic                  r0_gnt,
   output logic                  r1_gnt,
   output logic                  r0_rvalid,
   output logic                  r1_rvalid,
   output logic [WIDTH-1:0]      r0_rdata,
   output logic [WIDTH-1:0]      r1_rdata,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic [WIDTH-1:0]      mem_data,
   output logic                  mem_we,
   input  logic [WIDTH-1:0]      mem_q
);

   // last = id of the most recently granted requester; the other one wins a tie
   logic last_q, last_d;
   logic rr_gnt0, rr_gnt1;

   assign rr_gnt1 = r1_req && (!r0_req || (last_q == 1'b0));
   assign rr_gnt0 = r0_req && !rr_gnt1;

`ifdef ARB_BURST_LOCK_EN
   typedef enum logic [1:0] {IDLE, LOCK0, LOCK1} state_t;

   localparam logic [7:0] BURST_LAST = 8'(MAX_BURST - 1);

   state_t     state_q, state_d;
   logic [7:0] cnt_q, cnt_d;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      r0_gnt  = 1'b0;
      r1_gnt  = 1'b0;
      state_d = state_q;
      cnt_d   = cnt_q;
      last_d  = last_q;
      case (state_q)
         LOCK0: begin
            // Owner-only; leaving always hands the next tie to r1
            last_d = 1'b0;
            if (!r0_req) begin
               state_d = IDLE;
               cnt_d   = '0;
            end else begin
               r0_gnt = 1'b1;
               if (!r0_lock || cnt_q == BURST_LAST) begin
                  state_d = IDLE;
                  cnt_d   = '0;
               end else begin
                  cnt_d = cnt_q + 8'd1;
               end
            end
         end
         LOCK1: begin
            last_d = 1'b1;
            if (!r1_req) begin
               state_d = IDLE;
               cnt_d   = '0;
            end else begin
               r1_gnt = 1'b1;
               if (!r1_lock || cnt_q == BURST_LAST) begin
                  state_d = IDLE;
                  cnt_d   = '0;
               end else begin
                  cnt_d = cnt_q + 8'd1;
               end
            end
         end
         default: begin
            r0_gnt = rr_gnt0;
            r1_gnt = rr_gnt1;
            if (rr_gnt0) begin
               last_d = 1'b0;
               if (r0_lock) begin
                  state_d = LOCK0;
                  cnt_d   = 8'd1;
               end
            end else if (rr_gnt1) begin
               last_d = 1'b1;
               if (r1_lock) begin
                  state_d = LOCK1;
                  cnt_d   = 8'd1;
               end
            end
         end
      endcase
   end
`else
   // Lock inputs and burst bound have no function in this build
   logic unused_cfg;
   assign unused_cfg = r0_lock ^ r1_lock ^ MAX_BURST[0];

   always_comb begin
      r0_gnt = rr_gnt0;
      r1_gnt = rr_gnt1;
      last_d = last_q;
      if (rr_gnt0) begin
         last_d = 1'b0;
      end else if (rr_gnt1) begin
         last_d = 1'b1;
      end
   end
`endif

   logic any_gnt, sel_we;
   assign any_gnt = r0_gnt | r1_gnt;
   assign sel_we  = r1_gnt ? r1_we : r0_we;

   // Read tag pipeline: stage 0 lines up with mem_addr, stage RD_LATENCY with mem_q
   logic [RD_LATENCY:0] rd_vld_p;
   logic [RD_LATENCY:0] rd_id_p;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         last_q   <= 1'b1;
         mem_we   <= 1'b0;
         mem_addr <= '0;
         mem_data <= '0;
         rd_vld_p <= '0;
         rd_id_p  <= '0;
      end else begin
         last_q   <= last_d;
         // Grant stage -> memory port stage
         mem_we   <= any_gnt & sel_we;
         if (any_gnt) begin
            mem_addr <= r1_gnt ? r1_addr  : r0_addr;
            mem_data <= r1_gnt ? r1_wdata : r0_wdata;
         end
         // Memory port stage -> read return stage
         rd_vld_p <= {rd_vld_p[RD_LATENCY-1:0], any_gnt & ~sel_we};
         rd_id_p  <= {rd_id_p[RD_LATENCY-1:0], r1_gnt};
      end
   end

   assign r0_rvalid = rd_vld_p[RD_LATENCY] & ~rd_id_p[RD_LATENCY];
   assign r1_rvalid = rd_vld_p[RD_LATENCY] &  rd_id_p[RD_LATENCY];
   assign r0_rdata  = r0_rvalid ? mem_q : '0;
   assign r1_rdata  = r1_rvalid ? mem_q : '0;

endmodule

// File: tb/tb_bram_port_arbiter.sv
// -----------------------------------------------------------------------------
// tb_bram_port_arbiter
//
// Directed scoreboard bench for bram_port_arbiter (RD_LATENCY=1, MAX_BURST=4).
// Stimulus pushes expected grants, memory writes and read returns into queues;
// a negedge monitor pops and compares whenever the DUT presents them.
// Lock tests expect burst behaviour when ARB_BURST_LOCK_EN is defined and
// plain alternation otherwise.
// -----------------------------------------------------------------------------
module tb_bram_port_arbiter;

   localparam int W   = 16;
   localparam int AW  = 16;
   localparam int RDL = 1;
   localparam int MB  = 4;

   logic          clk = 1'b0;
   logic          reset;
   logic          r0_req, r0_we, r0_lock, r1_req, r1_we, r1_lock;
   logic [AW-1:0] r0_addr, r1_addr;
   logic [W-1:0]  r0_wdata, r1_wdata;
   logic          r0_gnt, r1_gnt, r0_rvalid, r1_rvalid;
   logic [W-1:0]  r0_rdata, r1_rdata;
   logic [AW-1:0] mem_addr;
   logic [W-1:0]  mem_data;
   logic          mem_we;
   logic [W-1:0]  mem_q = '0;

   bram_port_arbiter #(.WIDTH(W), .ADDR_WIDTH(AW), .RD_LATENCY(RDL), .MAX_BURST(MB)) dut (
      .clk(clk), .reset(reset),
      .r0_req(r0_req), .r0_we(r0_we), .r0_addr(r0_addr), .r0_wdata(r0_wdata), .r0_lock(r0_lock),
      .r1_req(r1_req), .r1_we(r1_we), .r1_addr(r1_addr), .r1_wdata(r1_wdata), .r1_lock(r1_lock),
      .r0_gnt(r0_gnt), .r1_gnt(r1_gnt), .r0_rvalid(r0_rvalid), .r1_rvalid(r1_rvalid),
      .r0_rdata(r0_rdata), .r1_rdata(r1_rdata),
      .mem_addr(mem_addr), .mem_data(mem_data), .mem_we(mem_we), .mem_q(mem_q)
   );

   always #5 clk = ~clk;

   // BRAM model, one-cycle read latency. Unwritten words read as 16'hA000|addr.
   logic [W-1:0] mem [0:255];
   logic [255:0] wrote = '0;
   always @(posedge clk) begin
      if (mem_we) begin
         mem[mem_addr[7:0]]   <= mem_data;
         wrote[mem_addr[7:0]] <= 1'b1;
      end
      mem_q <= wrote[mem_addr[7:0]] ? mem[mem_addr[7:0]] : (16'hA000 | {8'h00, mem_addr[7:0]});
   end

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct { logic id; logic [W-1:0] data; int cyc; } rd_t;
   typedef struct { logic [AW-1:0] addr; logic [W-1:0] data; int cyc; } wr_t;
   logic [1:0] gnt_q[$];
   rd_t        rd_q[$];
   wr_t        wr_q[$];

   int vectors = 0;
   int errors  = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic set0(input logic req, input logic we, input logic [AW-1:0] a,
                       input logic [W-1:0] d, input logic lk);
      r0_req = req; r0_we = we; r0_addr = a; r0_wdata = d; r0_lock = lk;
   endtask

   task automatic set1(input logic req, input logic we, input logic [AW-1:0] a,
                       input logic [W-1:0] d, input logic lk);
      r1_req = req; r1_we = we; r1_addr = a; r1_wdata = d; r1_lock = lk;
   endtask

   // Record the expected outcome of the current cycle's inputs, then advance
   task automatic step(input logic e0, input logic e1, input logic [W-1:0] exp_rd);
      gnt_q.push_back({e0, e1});
      if (e0) begin
         if (r0_we) wr_q.push_back('{r0_addr, r0_wdata, cyc + 1});
         else       rd_q.push_back('{1'b0, exp_rd, cyc + 1 + RDL});
      end else if (e1) begin
         if (r1_we) wr_q.push_back('{r1_addr, r1_wdata, cyc + 1});
         else       rd_q.push_back('{1'b1, exp_rd, cyc + 1 + RDL});
      end
      @(posedge clk); #1;
   endtask

   // Monitor
   always @(negedge clk) begin
      if (gnt_q.size() > 0) begin
         logic [1:0] eg;
         eg = gnt_q.pop_front();
         chk("grant{r0,r1}", {30'd0, r0_gnt, r1_gnt}, {30'd0, eg});
      end
      if (mem_we) begin
         if (wr_q.size() == 0) begin
            vectors++; errors++;
            $display("FAIL mem_we: got unexpected write addr %0h data %0h, expected none", mem_addr, mem_data);
         end else begin
            wr_t ew;
            ew = wr_q.pop_front();
            chk("wr_addr", {16'd0, mem_addr}, {16'd0, ew.addr});
            chk("wr_data", {16'd0, mem_data}, {16'd0, ew.data});
            chk("wr_cycle", cyc, ew.cyc);
         end
      end
      if (r0_rvalid && r1_rvalid) begin
         vectors++; errors++;
         $display("FAIL rvalid_both: got both rvalid high, expected at most one");
      end else if (r0_rvalid || r1_rvalid) begin
         if (rd_q.size() == 0) begin
            vectors++; errors++;
            $display("FAIL rvalid: got unexpected rvalid r%0d, expected none", r1_rvalid);
         end else begin
            rd_t er;
            er = rd_q.pop_front();
            chk("rd_id", {31'd0, r1_rvalid}, {31'd0, er.id});
            chk("rd_data", {16'd0, (r1_rvalid ? r1_rdata : r0_rdata)}, {16'd0, er.data});
            chk("rd_cycle", cyc, er.cyc);
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [4:0] pat;
      int i0, i1;
      reset = 1'b1;
      set0(0, 0, '0, '0, 0);
      set1(0, 0, '0, '0, 0);
      repeat (2) @(posedge clk);
      #1;
      chk("rst_mem_we",   {31'd0, mem_we}, 32'd0);
      chk("rst_mem_addr", {16'd0, mem_addr}, 32'd0);
      chk("rst_mem_data", {16'd0, mem_data}, 32'd0);
      chk("rst_rvalid",   {30'd0, r0_rvalid, r1_rvalid}, 32'd0);
      chk("rst_rdata",    {r0_rdata, r1_rdata}, 32'd0);
      chk("rst_gnt",      {30'd0, r0_gnt, r1_gnt}, 32'd0);
      reset = 1'b0;

      // r0 read in flight, then reset: its return must never appear
      set0(1, 0, 16'h0030, '0, 0);
      gnt_q.push_back(2'b10);
      @(posedge clk); #1;
      set0(0, 0, '0, '0, 0);
      reset = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;
      #1;
      chk("post_rst_mem_we",   {31'd0, mem_we}, 32'd0);
      chk("post_rst_mem_addr", {16'd0, mem_addr}, 32'd0);
      @(posedge clk); #1;

      // Tie after reset: r0 first, then r1
      set0(1, 0, 16'h0021, '0, 0);
      set1(1, 0, 16'h0022, '0, 0);
      step(1, 0, 16'hA021);
      // r0 now wants to write; r1 still pending and owed the tie
      set0(1, 1, 16'h0010, 16'hBEEF, 0);
      step(0, 1, 16'hA022);
      set1(0, 0, '0, '0, 0);
      step(1, 0, '0);
      set0(1, 0, 16'h0010, '0, 0);
      step(1, 0, 16'hBEEF);
      set0(0, 0, '0, '0, 0);
      set1(1, 0, 16'h0023, '0, 0);
      step(0, 1, 16'hA023);

      // Continuous contention: 0,1,0,1,0,1
      i0 = 0; i1 = 0;
      for (int k = 0; k < 6; k++) begin
         set0(1, 0, 16'h0040 + 16'(i0), '0, 0);
         set1(1, 0, 16'h0050 + 16'(i1), '0, 0);
         if (k % 2 == 0) begin step(1, 0, 16'hA040 + 16'(i0)); i0++; end
         else            begin step(0, 1, 16'hA050 + 16'(i1)); i1++; end
      end
      set0(0, 0, '0, '0, 0);
      set1(0, 0, '0, '0, 0);
      step(0, 0, '0);

      // r0 locked burst against a contending r1 (bit k set = r1 wins beat k)
`ifdef ARB_BURST_LOCK_EN
      pat = 5'b10000;
`else
      pat = 5'b01010;
`endif
      i0 = 0; i1 = 0;
      for (int k = 0; k < 5; k++) begin
         set0(1, 0, 16'h0060 + 16'(i0), '0, 1);
         set1(1, 0, 16'h0070 + 16'(i1), '0, 0);
         if (!pat[k]) begin step(1, 0, 16'hA060 + 16'(i0)); i0++; end
         else         begin step(0, 1, 16'hA070 + 16'(i1)); i1++; end
      end
      set0(0, 0, '0, '0, 0);
      set1(0, 0, '0, '0, 0);
      step(0, 0, '0);

      // r0 alone, so r1 wins the next tie
      set0(1, 0, 16'h0024, '0, 0);
      step(1, 0, 16'hA024);

      // r1 locks on beat 1 and drops lock on beat 2
`ifdef ARB_BURST_LOCK_EN
      pat = 5'b00011;
`else
      pat = 5'b00101;
`endif
      i0 = 0; i1 = 0;
      for (int k = 0; k < 3; k++) begin
         set0(1, 0, 16'h0080 + 16'(i0), '0, 0);
         set1(1, 0, 16'h0090 + 16'(i1), '0, (i1 == 0));
         if (!pat[k]) begin step(1, 0, 16'hA080 + 16'(i0)); i0++; end
         else         begin step(0, 1, 16'hA090 + 16'(i1)); i1++; end
      end
      set0(0, 0, '0, '0, 0);
      set1(0, 0, '0, '0, 0);
      step(0, 0, '0);

      for (int i = 0; i < 20 && (rd_q.size() + wr_q.size() + gnt_q.size()) > 0; i++)
         @(posedge clk);
      @(posedge clk); #1;
      chk("drain_pending", rd_q.size() + wr_q.size() + gnt_q.size(), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule

// File: doc/bram_port_arbiter.md
# bram_port_arbiter

Two-requester arbiter for the shared single-port side of the dual-port `bram`. It sits between two memory clients (for example a DMA/loader engine and a display scanner) and drives that BRAM port's `addr`/`data`/`we` while receiving its `q`. It grants one access per cycle with round-robin fairness, registers the winning access onto the memory port, and returns read data to the correct requester with a valid strobe. Optional burst locking lets one requester own the port for a bounded run of consecutive accesses.

## Interface
Parameters:
- `WIDTH`, 16, data width.
- `ADDR_WIDTH`, 16, address width.
- `RD_LATENCY`, 1, cycles from `mem_addr` being presented to `mem_q` valid (≥1).
- `MAX_BURST`, 8, maximum consecutive locked grants (2..255).

Ports:
- `clk`  in  1  single clock; all state on its rising edge.
- `reset`  in  1  asynchronous, active-high.
- `r0_req`, `r1_req`  in  1  access request; held with its qualifiers until granted.
- `r0_we`, `r1_we`  in  1  1 = write, 0 = read.
- `r0_addr`, `r1_addr`  in  ADDR_WIDTH  access address.
- `r0_wdata`, `r1_wdata`  in  WIDTH  write data.
- `r0_lock`, `r1_lock`  in  1  burst-lock request; used only with `ARB_BURST_LOCK_EN`.
- `r0_gnt`, `r1_gnt`  out  1  combinational grant; the access is accepted this cycle.
- `r0_rvalid`, `r1_rvalid`  out  1  one-cycle read-data strobe.
- `r0_rdata`, `r1_rdata`  out  WIDTH  read data; meaningful only while the matching `rvalid` is high.
- `mem_addr`  out  ADDR_WIDTH  registered address to BRAM.
- `mem_data`  out  WIDTH  registered write data to BRAM.
- `mem_we`  out  1  registered write enable; high for exactly one cycle per write.
- `mem_q`  in  WIDTH  BRAM read data.

## Operation
- At most one grant per cycle. `rN_gnt` is high only when `rN_req` is high.
- A single requester is granted immediately every cycle.
- If both request, grant the one not granted most recently (`last` pointer). With both continuously requesting, grants go 0,1,0,1,….
- On each grant, register `addr`/`wdata`/`we` onto `mem_*` at the next edge. With no grant, `mem_we` = 0 and `mem_addr`/`mem_data` hold their values.
- Each read grant pushes a tag (requester id) into a `RD_LATENCY+1`-deep valid pipeline. When the tag emerges, pulse that requester's `rvalid` and drive `mem_q` onto its `rdata`.
- Writes produce no `rvalid`.
- Grant order equals return order. Reads and writes may interleave freely.
- State machine (with the macro): `IDLE`, `LOCK0`, `LOCK1`.
  - `IDLE`: normal round-robin. A grant with `rN_lock`=1 enters `LOCKn` with the beat counter at 1.
  - `LOCKn`: only rN may be granted; the other requester is blocked.
  - Each further grant increments the counter.
  - Exit to `IDLE` when any of these holds: a granted beat has `rN_lock`=0; the counter reaches `MAX_BURST`; or `rN_req`=0 for a cycle.
  - On exit, `last` = n, so the other requester wins the next contention.

## Timing
- Reset values:
  - `rN_gnt`=0, `rN_rvalid`=0, `rN_rdata`=0.
  - `mem_we`=0, `mem_addr`=0, `mem_data`=0.
  - State `IDLE`, counter 0, `last`=1 (requester 0 wins the first tie), read pipeline empty.
- A grant in cycle N puts the access on `mem_*` in cycle N+1. For a read, `rvalid` and `rdata` are valid in cycle N+1+`RD_LATENCY`.
- Throughput: 1 access/cycle.
- Reset asserted mid-operation clears all state asynchronously. In-flight reads are discarded and no `rvalid` follows.
- A requester that drops `req` before its grant has cancelled its access; no side effect.

## Configuration
- `ARB_BURST_LOCK_EN` defined: lock inputs are honoured and the `IDLE`/`LOCK0`/`LOCK1` FSM and burst counter are built.
- Not defined: `rN_lock` is ignored, there is no FSM, and arbitration is pure per-cycle round-robin.

## Test plan
- Reset asserted while r0 has a read in flight → no `r0_rvalid`; after release, `mem_we`=0, `mem_addr`=0, and on a tie r0 is granted first.
- r0 writes 0xBEEF to 0x0010, then reads 0x0010 → `mem_we` high for one cycle; `r0_rvalid` 2 cycles after the read grant (`RD_LATENCY`=1) with `r0_rdata`=0xBEEF.
- r0 and r1 request continuously for 6 cycles → grants 0,1,0,1,0,1, never both high; each read returns to the correct requester in order.
- `ARB_BURST_LOCK_EN`, `MAX_BURST`=4, r0 locked burst while r1 also requests → r0 granted 4 consecutive cycles, then r1 granted.
- `ARB_BURST_LOCK_EN`, r1 lock with `r1_lock` dropped on beat 2 → r0 granted in the next cycle.
- Macro undefined, r0 asserts lock with r1 contending → strict alternation, lock ignored.
